// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the calculator keypad path.
package calc_pkg;

   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_CLEAR = 4'hB;
   localparam logic [3:0] KEY_BACK  = 4'hC;

   localparam int         DEF_WIDTH   = 8;
   localparam logic [9:0] OPERAND_MAX = 10'd255;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTRY = 2'd1,
      S_LOAD  = 2'd2,
      S_ERROR = 2'd3
   } state_t;

endpackage

// File: rtl/bcd_to_bin.sv
// Three-digit BCD to 10-bit binary with an over-range flag (> OPERAND_MAX).
module bcd_to_bin
   import calc_pkg::*;
(
   input  logic [3:0] i_d2,
   input  logic [3:0] i_d1,
   input  logic [3:0] i_d0,
   output logic [9:0] o_bin,
   output logic       o_ovr
);

   logic [9:0] w_bin;

   assign w_bin = 10'(i_d2) * 10'd100
                + 10'(i_d1) * 10'd10
                + 10'(i_d0);

   assign o_bin = w_bin;
   assign o_ovr = (w_bin > OPERAND_MAX);

endmodule

// File: rtl/operand_entry.sv
// Keypad operand accumulator feeding the operand register enable/data.
// OPERAND_SAT_EN: overflow clamps to 255 with a sticky err instead of ERROR.
module operand_entry
   import calc_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int MAX_DIGITS = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   input  logic [3:0]       key_code,
   output logic [WIDTH-1:0] operand,
   output logic             load_en,
   output logic [1:0]       digit_cnt,
   output logic             err,
   output logic             busy
);

   state_t     r_state;
   state_t     w_nxt;
   logic [3:0] r_d0, r_d1, r_d2;
   logic [3:0] w_d0, w_d1, w_d2;
   logic [1:0] r_cnt, w_cnt;
   logic       r_err, w_err;
   logic       r_load;

   logic [9:0] w_held_bin;
   logic       w_held_ovr;
   logic [9:0] w_cand_bin;
   logic       w_cand_ovr;
   logic [9:0] w_clamped;
   logic       w_is_dig;
   logic       w_full;
   logic       w_unused;

   bcd_to_bin u_held (
      .i_d2  (r_d2),
      .i_d1  (r_d1),
      .i_d0  (r_d0),
      .o_bin (w_held_bin),
      .o_ovr (w_held_ovr)
   );

   // Candidate is the held value with the new key shifted in.
   bcd_to_bin u_cand (
      .i_d2  (r_d1),
      .i_d1  (r_d0),
      .i_d0  (key_code),
      .o_bin (w_cand_bin),
      .o_ovr (w_cand_ovr)
   );

   assign w_unused  = ^w_cand_bin;
   assign w_is_dig  = (key_code <= 4'd9);
   assign w_full    = (r_cnt == 2'(MAX_DIGITS));
   assign w_clamped = w_held_ovr ? OPERAND_MAX : w_held_bin;

   always_comb begin
      w_nxt = r_state;
      w_d0  = r_d0;
      w_d1  = r_d1;
      w_d2  = r_d2;
      w_cnt = r_cnt;
      w_err = r_err;
      unique case (r_state)
         S_IDLE: begin
            if (key_valid && w_is_dig) begin
               w_d0  = key_code;
               w_cnt = 2'd1;
               w_nxt = S_ENTRY;
            end else if (key_valid && key_code == KEY_ENTER) begin
               w_nxt = S_LOAD;
            end
         end
         S_ENTRY: begin
            if (key_valid && w_is_dig) begin
               if (!w_full) begin
                  if (!w_cand_ovr) begin
                     w_d2  = r_d1;
                     w_d1  = r_d0;
                     w_d0  = key_code;
                     w_cnt = r_cnt + 2'd1;
                  end else begin
`ifdef OPERAND_SAT_EN
                     w_d2  = r_d1;
                     w_d1  = r_d0;
                     w_d0  = key_code;
                     w_cnt = r_cnt + 2'd1;
                     w_err = 1'b1;
`else
                     w_err = 1'b1;
                     w_nxt = S_ERROR;
`endif
                  end
               end
            end else if (key_valid && key_code == KEY_BACK) begin
               w_d0  = r_d1;
               w_d1  = r_d2;
               w_d2  = 4'd0;
               w_cnt = r_cnt - 2'd1;
               if (r_cnt == 2'd1) w_nxt = S_IDLE;
            end else if (key_valid && key_code == KEY_CLEAR) begin
               w_d0  = 4'd0;
               w_d1  = 4'd0;
               w_d2  = 4'd0;
               w_cnt = 2'd0;
               w_err = 1'b0;
               w_nxt = S_IDLE;
            end else if (key_valid && key_code == KEY_ENTER) begin
               w_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_d0  = 4'd0;
            w_d1  = 4'd0;
            w_d2  = 4'd0;
            w_cnt = 2'd0;
            w_err = 1'b0;
            w_nxt = S_IDLE;
         end
         S_ERROR: begin
            if (key_valid && key_code == KEY_CLEAR) begin
               w_d0  = 4'd0;
               w_d1  = 4'd0;
               w_d2  = 4'd0;
               w_cnt = 2'd0;
               w_err = 1'b0;
               w_nxt = S_IDLE;
            end
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_d0    <= 4'd0;
         r_d1    <= 4'd0;
         r_d2    <= 4'd0;
         r_cnt   <= 2'd0;
         r_err   <= 1'b0;
         r_load  <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_d0    <= w_d0;
         r_d1    <= w_d1;
         r_d2    <= w_d2;
         r_cnt   <= w_cnt;
         r_err   <= w_err;
         r_load  <= (w_nxt == S_LOAD);
      end
   end

   assign operand   = w_clamped[WIDTH-1:0];
   assign load_en   = r_load;
   assign digit_cnt = r_cnt;
   assign err       = r_err;
   assign busy      = (r_state == S_LOAD);

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a model of the downstream register.
module tb_operand_entry;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid;
   logic [3:0] key_code;
   logic [7:0] operand;
   logic       load_en;
   logic [1:0] digit_cnt;
   logic       err;
   logic       busy;
   logic [7:0] r_reg;
   int         checks = 0;
   int         errors = 0;

   operand_entry dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .operand   (operand),
      .load_en   (load_en),
      .digit_cnt (digit_cnt),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (rst) r_reg <= 8'h00;
      else if (load_en) r_reg <= operand;

   // Called at a negedge; holds the key for one cycle, returns at the next negedge.
   task automatic key(input logic [3:0] k);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'h0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({operand, load_en, digit_cnt, err, busy} !== 13'd0) begin
         errors++;
         $display("FAIL reset outs got %h want 0",
                  {operand, load_en, digit_cnt, err, busy});
      end
   endtask

   task automatic test_load_123();
      key(4'd1); key(4'd2); key(4'd3);
      checks++;
      if (digit_cnt !== 2'd3) begin
         errors++;
         $display("FAIL cnt_123 got %0d want 3", digit_cnt);
      end
      key(4'hA);
      checks++;
      if (load_en !== 1'b1 || operand !== 8'h7B || busy !== 1'b1) begin
         errors++;
         $display("FAIL load_123 got le=%b op=%h bz=%b want 1 7b 1",
                  load_en, operand, busy);
      end
      @(negedge clk);
      checks++;
      if (load_en !== 1'b0 || digit_cnt !== 2'd0 || r_reg !== 8'h7B) begin
         errors++;
         $display("FAIL after_123 got le=%b cnt=%0d reg=%h want 0 0 7b",
                  load_en, digit_cnt, r_reg);
      end
   endtask

   task automatic test_load_255();
      key(4'd2); key(4'd5); key(4'd5);
      checks++;
      if (operand !== 8'd255 || err !== 1'b0) begin
         errors++;
         $display("FAIL val_255 got op=%0d err=%b want 255 0", operand, err);
      end
      key(4'hA);
      checks++;
      if (load_en !== 1'b1 || operand !== 8'd255) begin
         errors++;
         $display("FAIL load_255 got le=%b op=%0d want 1 255", load_en, operand);
      end
      @(negedge clk);
   endtask

   task automatic test_overflow();
      key(4'd2); key(4'd5); key(4'd6);
`ifdef OPERAND_SAT_EN
      checks++;
      if (operand !== 8'd255 || err !== 1'b1 || digit_cnt !== 2'd3) begin
         errors++;
         $display("FAIL sat got op=%0d err=%b cnt=%0d want 255 1 3",
                  operand, err, digit_cnt);
      end
      key(4'hA);
      checks++;
      if (load_en !== 1'b1 || operand !== 8'd255) begin
         errors++;
         $display("FAIL sat_load got le=%b op=%0d want 1 255", load_en, operand);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || r_reg !== 8'd255) begin
         errors++;
         $display("FAIL sat_after got err=%b reg=%0d want 0 255", err, r_reg);
      end
`else
      checks++;
      if (err !== 1'b1 || operand !== 8'd25 || digit_cnt !== 2'd2) begin
         errors++;
         $display("FAIL ovf got err=%b op=%0d cnt=%0d want 1 25 2",
                  err, operand, digit_cnt);
      end
      key(4'hA);
      checks++;
      if (load_en !== 1'b0 || err !== 1'b1) begin
         errors++;
         $display("FAIL ovf_enter got le=%b err=%b want 0 1", load_en, err);
      end
      key(4'd3);
      checks++;
      if (load_en !== 1'b0 || operand !== 8'd25) begin
         errors++;
         $display("FAIL ovf_hold got le=%b op=%0d want 0 25", load_en, operand);
      end
      key(4'hB);
      checks++;
      if (err !== 1'b0 || digit_cnt !== 2'd0 || operand !== 8'd0) begin
         errors++;
         $display("FAIL ovf_clear got err=%b cnt=%0d op=%0d want 0 0 0",
                  err, digit_cnt, operand);
      end
`endif
   endtask

   task automatic test_backspace();
      key(4'd4); key(4'd7); key(4'hC);
      checks++;
      if (operand !== 8'd4 || digit_cnt !== 2'd1) begin
         errors++;
         $display("FAIL bksp got op=%0d cnt=%0d want 4 1", operand, digit_cnt);
      end
      key(4'd9); key(4'hA);
      checks++;
      if (load_en !== 1'b1 || operand !== 8'd49) begin
         errors++;
         $display("FAIL load_49 got le=%b op=%0d want 1 49", load_en, operand);
      end
      @(negedge clk);
      key(4'd1); key(4'hC);
      checks++;
      if (digit_cnt !== 2'd0 || operand !== 8'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bksp_idle got cnt=%0d op=%0d want 0 0", digit_cnt, operand);
      end
      key(4'hE);
      checks++;
      if (digit_cnt !== 2'd0 || load_en !== 1'b0) begin
         errors++;
         $display("FAIL ignored got cnt=%0d le=%b want 0 0", digit_cnt, load_en);
      end
   endtask

   task automatic test_enter_empty();
      do_reset();
      key(4'hA);
      checks++;
      if (load_en !== 1'b1 || operand !== 8'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL enter0 got le=%b op=%0d bz=%b want 1 0 1",
                  load_en, operand, busy);
      end
      @(negedge clk);
   endtask

   task automatic test_fourth_digit();
      key(4'd1); key(4'd2); key(4'd3); key(4'd4);
      checks++;
      if (operand !== 8'd123 || digit_cnt !== 2'd3) begin
         errors++;
         $display("FAIL fourth got op=%0d cnt=%0d want 123 3", operand, digit_cnt);
      end
      key(4'hB);
   endtask

   task automatic test_key_during_load();
      key(4'd5); key(4'hA);
      key(4'd8);
      checks++;
      if (load_en !== 1'b0 || digit_cnt !== 2'd0 || operand !== 8'd0) begin
         errors++;
         $display("FAIL drop got le=%b cnt=%0d op=%0d want 0 0 0",
                  load_en, digit_cnt, operand);
      end
      key(4'd3);
      checks++;
      if (operand !== 8'd3 || digit_cnt !== 2'd1) begin
         errors++;
         $display("FAIL fresh got op=%0d cnt=%0d want 3 1", operand, digit_cnt);
      end
      key(4'hB);
   endtask

   task automatic test_reset_mid();
      key(4'd9); key(4'd9);
      rst = 1'b1;
      key(4'hA);
      rst = 1'b0;
      checks++;
      if ({operand, load_en, digit_cnt, err, busy} !== 13'd0) begin
         errors++;
         $display("FAIL rst_mid got %h want 0",
                  {operand, load_en, digit_cnt, err, busy});
      end
      @(negedge clk);
      checks++;
      if (load_en !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid2 got le=%b bz=%b want 0 0", load_en, busy);
      end
   endtask

   initial begin
      rst       = 1'b1;
      key_valid = 1'b0;
      key_code  = 4'h0;
      @(negedge clk);
      test_reset();
      test_load_123();
      test_load_255();
      test_overflow();
      test_backspace();
      test_enter_empty();
      test_fourth_digit();
      test_key_during_load();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
